shift_rotate_unit: RTL
======================

Name: shift_rotate_unit

Overview:
Iterative multi-cycle shift/rotate unit in the datapath, one bit position per clock. Directly upstream of the carry and zero flag one-bit registers. Reads the current carry flag for rotate-through-carry. Drives each flag register's WRITE/WRITE_DATA pair with the completion flags.

Parameters:
WIDTH, 8, operand/result width in bits
AMT_W, 4, shift-amount field width; amounts 0..2^AMT_W-1 are legal, including amounts >= WIDTH

Ports:
CLK  input  1  datapath clock; all state updates on negedge CLK
RST  input  1  reset, asynchronous, active-low
START  input  1  request; sampled only in IDLE
OP  input  3  operation code (shared package encoding)
AMT  input  AMT_W  shift count
OPERAND  input  WIDTH  value to shift
CARRY_IN  input  1  current carry flag (carry register READ_DATA)
BUSY  output  1  high in SHIFT state
DONE  output  1  one-cycle completion pulse
RESULT  output  WIDTH  shifted value; held from DONE until the next accepted START
CARRY_WRITE  output  1  write strobe to carry flag register
CARRY_OUT  output  1  new carry value (carry register WRITE_DATA)
ZERO_WRITE  output  1  write strobe to zero flag register
ZERO_OUT  output  1  high when RESULT == 0

Behaviour:
- Reset (RST low, any time, including mid-operation):
  - state IDLE; RESULT = 0; BUSY, DONE, CARRY_WRITE, ZERO_WRITE, CARRY_OUT = 0; ZERO_OUT = 1.
  - An aborted operation produces no flag write.
- States:
  - IDLE: on START, latch OPERAND, OP, AMT and CARRY_IN into work registers and load the counter with AMT. Go to SHIFT if AMT != 0, else go to DONE.
  - SHIFT: each negedge performs one step on the work value and work carry, then decrements the counter. When the counter goes 1 -> 0, go to DONE.
  - DONE: one cycle. DONE = 1; RESULT = work value; CARRY_OUT = work carry; ZERO_WRITE = 1; CARRY_WRITE = 1 only if the latched AMT != 0. Then go to IDLE.
- Latency: START edge to DONE cycle = AMT + 1 cycles. The flag registers capture on the negedge that ends the DONE cycle.
- START in SHIFT or DONE is ignored; no queuing.
- CARRY_IN is sampled only at START. Later changes to CARRY_IN have no effect on an operation in progress.
- Single step, where v is the work value and c the work carry:
  - SHL: c = v[W-1]; v = {v[W-2:0], 0}.
  - SHR: c = v[0]; v = {0, v[W-1:1]}.
  - ASR: c = v[0]; v = {v[W-1], v[W-1:1]}.
  - ROL: c = v[W-1]; v = {v[W-2:0], v[W-1]}.
  - ROR: c = v[0]; v = {v[0], v[W-1:1]}.
  - RCL: {c, v} rotated left as a (W+1)-bit quantity.
  - RCR: {v, c} rotated right as a (W+1)-bit quantity.
- NOP (code 3'b111): takes the AMT==0 path regardless of AMT. RESULT = OPERAND, CARRY_WRITE = 0, ZERO_WRITE = 0.
- AMT >= WIDTH is iterated literally:
  - SHL/SHR give 0 with the expected carry.
  - RCL/RCR wrap modulo W+1.
- Outputs outside DONE: strobes and DONE are 0; RESULT, CARRY_OUT and ZERO_OUT hold their last values.

Decomposition:
- Shared package nark_alu_pkg:
  - typedef enum logic [2:0] shift_op_t: SHL = 0, SHR = 1, ASR = 2, ROL = 3, ROR = 4, RCL = 5, RCR = 6, NOP = 7.
  - typedef enum state_t: IDLE, SHIFT, DONE.
- Sub-module shift_step: purely combinational single-bit step (op, v, c -> v', c'), instantiated once.

Test Plan:
1. SHL, OPERAND = 8'h81, AMT = 1, CARRY_IN = 0 -> DONE 2 cycles after START; RESULT = 8'h02, CARRY_OUT = 1, ZERO_OUT = 0, both strobes = 1.
2. SHR, 8'h01, AMT = 1 -> RESULT = 8'h00, CARRY_OUT = 1, ZERO_OUT = 1.
3. ASR, 8'h80, AMT = 3 -> BUSY for 3 cycles, DONE in cycle 4; RESULT = 8'hF0, CARRY_OUT = 0.
4. RCL, 8'h80, CARRY_IN = 1, AMT = 1 -> RESULT = 8'h01, CARRY_OUT = 1. RCR, 8'h01, CARRY_IN = 0, AMT = 9 -> RESULT = 8'h01, CARRY_OUT = 0.
5. ROL, 8'h3C, AMT = 0 -> DONE 1 cycle after START; RESULT = 8'h3C, CARRY_WRITE = 0, ZERO_WRITE = 1. NOP with AMT = 5 -> DONE after 1 cycle, no strobes.
6. SHL, AMT = 6:
   - Second START at cycle 2 -> ignored.
   - RST low at cycle 4 -> IDLE, outputs at reset values, no strobe ever pulses.
   - New START after reset release completes normally.

Source files
------------

// File: rtl/nark_alu_pkg.sv
// rtl/nark_alu_pkg.sv - shared ALU op codes and shift unit state encoding
package nark_alu_pkg;

    typedef enum logic [2:0] {
        SHL = 3'd0,
        SHR = 3'd1,
        ASR = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4,
        RCL = 3'd5,
        RCR = 3'd6,
        NOP = 3'd7
    } shift_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one-bit-position shift/rotate step on a value and carry
module shift_step
    import nark_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] v,
    input  logic             c,
    output logic [WIDTH-1:0] v_next,
    output logic             c_next
);

    always_comb begin
        v_next = v;
        c_next = c;
        case (op)
            SHL: begin
                c_next = v[WIDTH-1];
                v_next = {v[WIDTH-2:0], 1'b0};
            end
            SHR: begin
                c_next = v[0];
                v_next = {1'b0, v[WIDTH-1:1]};
            end
            ASR: begin
                c_next = v[0];
                v_next = {v[WIDTH-1], v[WIDTH-1:1]};
            end
            ROL: begin
                c_next = v[WIDTH-1];
                v_next = {v[WIDTH-2:0], v[WIDTH-1]};
            end
            ROR: begin
                c_next = v[0];
                v_next = {v[0], v[WIDTH-1:1]};
            end
            // Rotate-through-carry treats {c, v} as one WIDTH+1 bit ring.
            RCL: begin
                c_next = v[WIDTH-1];
                v_next = {v[WIDTH-2:0], c};
            end
            RCR: begin
                c_next = v[0];
                v_next = {c, v[WIDTH-1:1]};
            end
            default: begin
                v_next = v;
                c_next = c;
            end
        endcase
    end

endmodule

// File: rtl/shift_rotate_unit.sv
// rtl/shift_rotate_unit.sv - iterative shift/rotate unit feeding the carry and zero flag registers
module shift_rotate_unit
    import nark_alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic [AMT_W-1:0] AMT,
    input  logic [WIDTH-1:0] OPERAND,
    input  logic             CARRY_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY_WRITE,
    output logic             CARRY_OUT,
    output logic             ZERO_WRITE,
    output logic             ZERO_OUT
);

    state_t           state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] work_v;
    logic             work_c;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] step_v;
    logic             step_c;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op     (op_r),
        .v      (work_v),
        .c      (work_c),
        .v_next (step_v),
        .c_next (step_c)
    );

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            op_r        <= NOP;
            work_v      <= '0;
            work_c      <= 1'b0;
            cnt         <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RESULT      <= '0;
            CARRY_WRITE <= 1'b0;
            CARRY_OUT   <= 1'b0;
            ZERO_WRITE  <= 1'b0;
            ZERO_OUT    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    DONE        <= 1'b0;
                    CARRY_WRITE <= 1'b0;
                    ZERO_WRITE  <= 1'b0;
                    if (START) begin
                        op_r   <= OP;
                        work_v <= OPERAND;
                        work_c <= CARRY_IN;
                        cnt    <= AMT;
                        // Zero-length and NOP operations skip SHIFT and finish with the operand untouched.
                        if (OP == NOP || AMT == '0) begin
                            state      <= nark_alu_pkg::DONE;
                            DONE       <= 1'b1;
                            RESULT     <= OPERAND;
                            CARRY_OUT  <= CARRY_IN;
                            ZERO_OUT   <= (OPERAND == '0);
                            ZERO_WRITE <= (OP != NOP);
                        end else begin
                            state <= SHIFT;
                            BUSY  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt == AMT_W'(1)) begin
                        state       <= nark_alu_pkg::DONE;
                        BUSY        <= 1'b0;
                        DONE        <= 1'b1;
                        RESULT      <= step_v;
                        CARRY_OUT   <= step_c;
                        ZERO_OUT    <= (step_v == '0);
                        ZERO_WRITE  <= 1'b1;
                        CARRY_WRITE <= 1'b1;
                    end
                    work_v <= step_v;
                    work_c <= step_c;
                    cnt    <= cnt - AMT_W'(1);
                end
                nark_alu_pkg::DONE: begin
                    state       <= IDLE;
                    DONE        <= 1'b0;
                    CARRY_WRITE <= 1'b0;
                    ZERO_WRITE  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule
